// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command responder.
// Holds frame markers, command codes, response status codes, the
// parser/transmit state encodings and a constant clog2 helper.
package uart_pkg;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CHK  = 8'h01;
    localparam logic [7:0] ST_BAD_CMD  = 8'h02;
    localparam logic [7:0] ST_BAD_ADDR = 8'h03;

    typedef enum logic [2:0] {
        HUNT,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        CAPTURE,
        RESPOND
    } parse_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        RESP_LOAD,
        RESP_BUSY,
        RESP_DONE
    } tx_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Sends a 4-byte response through a UART transmitter using a
// transmit/is_transmitting handshake sized for a UART that stays busy
// until transmit drops.
// Ports:
//   clk_i, rst_i    clock, async active-high reset
//   start_i         one-cycle request to send bytes_i (bytes_i[0] first)
//   bytes_i         response bytes, sampled on start_i
//   tx_busy_i       UART transmitter busy
//   transmit_o      send request to the UART
//   tx_byte_o       byte to send, stable while transmit_o is high
//   done_o          high in the cycle the last byte completes
module uart_tx_sequencer
    import uart_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [3:0][7:0] bytes_i,
    input  logic            tx_busy_i,
    output logic            transmit_o,
    output logic [7:0]      tx_byte_o,
    output logic            done_o
);

    tx_state_t       state_q;
    logic [3:0][7:0] buf_q;
    logic [1:0]      idx_q;

    assign done_o = (state_q == RESP_DONE) && !tx_busy_i && (idx_q == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TX_IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            transmit_o <= 1'b0;
            tx_byte_o  <= '0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (start_i) begin
                        buf_q <= bytes_i;
                        idx_q <= '0;
                        // Load byte 0 on the start edge when the UART is idle,
                        // so the first byte goes out the cycle after start.
                        if (!tx_busy_i) begin
                            transmit_o <= 1'b1;
                            tx_byte_o  <= bytes_i[0];
                            state_q    <= RESP_BUSY;
                        end else begin
                            state_q <= RESP_LOAD;
                        end
                    end
                end
                RESP_LOAD: begin
                    if (!tx_busy_i) begin
                        transmit_o <= 1'b1;
                        tx_byte_o  <= buf_q[idx_q];
                        state_q    <= RESP_BUSY;
                    end
                end
                RESP_BUSY: begin
                    if (tx_busy_i) begin
                        transmit_o <= 1'b0;
                        state_q    <= RESP_DONE;
                    end
                end
                RESP_DONE: begin
                    if (!tx_busy_i) begin
                        if (idx_q == 2'd3) begin
                            state_q <= TX_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= RESP_LOAD;
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Command-side peer of a UART core. Parses 5-byte request frames
// (A5 CMD ADDR DATA CHK), performs a register read or write on an 8-bit
// register bus and answers with a 4-byte response (5A STATUS RDATA CHK).
// Ports:
//   clk, rst                    clock, async active-high reset
//   received, rx_byte           receive strobe and byte from the UART
//   recv_error                  UART framing error strobe
//   transmit, tx_byte           transmit request and byte to the UART
//   is_transmitting             UART transmitter busy
//   reg_we, reg_addr, reg_wdata register bus write strobe/address/data
//   reg_rdata                   register read data (one cycle after addr)
//   frame_ok, frame_err         per-frame result pulses
//   busy                        high whenever the parser is not hunting
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ   = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned NUM_REGS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       is_transmitting,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    // A zero timeout would abort every frame; fall back to 20 ms instead.
    localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? SYS_CLK_FREQ / 50 : TIMEOUT_CYCLES;
    localparam int unsigned TO_W     = clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_LIMIT);

    parse_state_t    state_q;
    logic [7:0]      cmd_q;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic [7:0]      status_q;
    logic [7:0]      status_d;
    logic [TO_W-1:0] cnt_q;
    logic [7:0]      rdata;
    logic [3:0][7:0] rsp_bytes;
    logic            seq_start;
    logic            seq_done;

    assign busy      = (state_q != HUNT);
    assign seq_start = (state_q == CAPTURE);

    // Status evaluated in GET_CHK with rx_byte as the checksum byte;
    // checksum has priority over command, command over address.
    always_comb begin
        status_d = ST_OK;
        if ((cmd_q ^ addr_q ^ data_q) != rx_byte) begin
            status_d = ST_BAD_CHK;
        end else if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
            status_d = ST_BAD_CMD;
        end else if (32'(addr_q) >= NUM_REGS) begin
            status_d = ST_BAD_ADDR;
        end
    end

    always_comb begin
        rdata = '0;
        if (status_q == ST_OK && cmd_q == CMD_RD) begin
            rdata = reg_rdata;
        end
        rsp_bytes[0] = SOF_RSP;
        rsp_bytes[1] = status_q;
        rsp_bytes[2] = rdata;
        rsp_bytes[3] = status_q ^ rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            status_q  <= '0;
            cnt_q     <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                HUNT: begin
                    cnt_q <= '0;
                    if (received && rx_byte == SOF_REQ) begin
                        state_q <= GET_CMD;
                    end
                end
                GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
                    // recv_error is tested first so it wins over a coincident byte.
                    if (recv_error || cnt_q == TO_MAX) begin
                        frame_err <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= HUNT;
                    end else if (received) begin
                        cnt_q <= '0;
                        case (state_q)
                            GET_CMD: begin
                                cmd_q   <= rx_byte;
                                state_q <= GET_ADDR;
                            end
                            GET_ADDR: begin
                                addr_q  <= rx_byte;
                                state_q <= GET_DATA;
                            end
                            GET_DATA: begin
                                data_q  <= rx_byte;
                                state_q <= GET_CHK;
                            end
                            default: begin
                                status_q  <= status_d;
                                reg_addr  <= addr_q;
                                reg_wdata <= data_q;
                                reg_we    <= (cmd_q == CMD_WR) && (status_d == ST_OK);
                                state_q   <= EXEC;
                            end
                        endcase
                    end else if (cnt_q != TO_MAX) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                EXEC: begin
                    frame_ok  <= (status_q == ST_OK);
                    frame_err <= (status_q != ST_OK);
                    state_q   <= CAPTURE;
                end
                CAPTURE: begin
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    if (seq_done) begin
                        state_q <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    uart_tx_sequencer u_tx_seq (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (seq_start),
        .bytes_i    (rsp_bytes),
        .tx_busy_i  (is_transmitting),
        .transmit_o (transmit),
        .tx_byte_o  (tx_byte),
        .done_o     (seq_done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

    localparam int T_OUT   = 100;
    localparam int NREGS   = 16;
    localparam int UART_HOLD = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting = 1'b0;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    uart_cmd_responder #(
        .SYS_CLK_FREQ   (100000000),
        .TIMEOUT_CYCLES (T_OUT),
        .NUM_REGS       (NREGS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .frame_ok        (frame_ok),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register bus slave: read data appears one cycle after the address.
    logic [7:0] regmem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) regmem[i] <= 8'(i * 12);
        end else if (reg_we) begin
            regmem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= regmem[reg_addr];
    end

    // UART transmitter model: busy UART_HOLD cycles, then until transmit drops.
    logic [7:0] rx_log [1024];
    int rx_n = 0;
    int u_cnt = 0;
    always @(posedge clk) begin
        if (!is_transmitting) begin
            if (transmit) begin
                is_transmitting <= 1'b1;
                u_cnt <= UART_HOLD;
                rx_log[rx_n] <= tx_byte;
                rx_n <= rx_n + 1;
            end
        end else begin
            if (u_cnt != 0) u_cnt <= u_cnt - 1;
            else if (!transmit) is_transmitting <= 1'b0;
        end
    end

    // Event monitors, sampled mid-cycle.
    int rise_cyc [1024];
    int rise_n = 0, viol_n = 0, overlap_n = 0;
    int we_n = 0, we_cyc = 0, ok_n = 0, ok_cyc = 0, err_n = 0, err_cyc = 0;
    logic [7:0] we_addr = '0, we_data = '0, txb_prev = '0;
    logic tx_prev = 1'b0;
    always @(negedge clk) begin
        tx_prev  <= transmit;
        txb_prev <= tx_byte;
        if (transmit && !tx_prev) begin
            rise_cyc[rise_n] <= cyc;
            rise_n <= rise_n + 1;
        end
        viol_n <= viol_n + int'(transmit && !tx_prev && is_transmitting)
                         + int'(transmit && tx_prev && tx_byte != txb_prev);
        overlap_n <= overlap_n + int'(transmit && is_transmitting);
        if (reg_we) begin
            we_n <= we_n + 1; we_cyc <= cyc; we_addr <= reg_addr; we_data <= reg_wdata;
        end
        if (frame_ok) begin ok_n <= ok_n + 1; ok_cyc <= cyc; end
        if (frame_err) begin err_n <= err_n + 1; err_cyc <= cyc; end
    end

    int total = 0;
    int bad = 0;
    logic [7:0] shadow [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte = b;
        tick();
        received = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic wait_resp(input int rb, output logic [31:0] rsp);
        int k = 0;
        while (!((rx_n - rb) >= 4 && !busy) && k < 3000) begin
            tick();
            k++;
        end
        check("resp_wait_bound", 32'(k >= 3000), 32'd0);
        rsp = {rx_log[rb], rx_log[rb+1], rx_log[rb+2], rx_log[rb+3]};
    endtask

    task automatic do_frame(input string tag, input logic [39:0] fr, input int gap,
                            input logic [31:0] exp_rsp, input bit exp_we, input bit strict);
        int rb, sb, wb, ob, eb, vb, lb, n;
        logic [31:0] rsp;
        bit exp_ok;
        rb = rx_n; sb = rise_n; wb = we_n; ob = ok_n; eb = err_n; vb = viol_n; lb = overlap_n;
        n = 0;
        exp_ok = (exp_rsp[23:16] == 8'h00);
        for (int i = 0; i < 5; i++) begin
            repeat (gap) tick();
            if (i == 4) n = cyc;
            send_byte(fr[39-8*i -: 8]);
        end
        wait_resp(rb, rsp);
        check({tag, " response"}, rsp, exp_rsp);
        check({tag, " we_count"}, 32'(we_n - wb), 32'(exp_we));
        if (exp_we) begin
            check({tag, " we_addr"}, 32'(we_addr), 32'(fr[23:16]));
            check({tag, " we_data"}, 32'(we_data), 32'(fr[15:8]));
            check({tag, " we_cycle"}, 32'(we_cyc - n), 32'd1);
        end
        check({tag, " ok_count"}, 32'(ok_n - ob), 32'(exp_ok));
        check({tag, " err_count"}, 32'(err_n - eb), 32'(!exp_ok));
        check({tag, " result_cycle"}, 32'((exp_ok ? ok_cyc : err_cyc) - n), 32'd2);
        if (strict) check({tag, " first_tx_cycle"}, 32'(rise_cyc[sb] - n), 32'd3);
        check({tag, " busy_overlap"}, 32'(overlap_n - lb), 32'd4);
        check({tag, " handshake_viol"}, 32'(viol_n - vb), 32'd0);
    endtask

    typedef struct {
        logic [39:0] frame;
        int          gap;
        logic [31:0] rsp;
        bit          we;
    } vec_t;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vt [11];
        int rb, sb, wb, eb, k, c;
        logic [31:0] rsp;

        vt[0]  = '{40'hA5_57_03_C4_90, 0,  32'h5A_00_00_00, 1'b1};  // write
        vt[1]  = '{40'hA5_52_05_00_57, 1,  32'h5A_00_3C_3C, 1'b0};  // read
        vt[2]  = '{40'hA5_57_03_C4_00, 2,  32'h5A_01_00_01, 1'b0};  // bad checksum
        vt[3]  = '{40'hA5_11_03_C4_D6, 0,  32'h5A_02_00_02, 1'b0};  // bad cmd
        vt[4]  = '{40'hA5_52_20_00_72, 3,  32'h5A_03_00_03, 1'b0};  // bad addr
        vt[5]  = '{40'hA5_52_03_00_51, 0,  32'h5A_00_C4_C4, 1'b0};  // read back write
        vt[6]  = '{40'hA5_57_0F_5A_02, 1,  32'h5A_00_00_00, 1'b1};  // last valid addr
        vt[7]  = '{40'hA5_52_10_00_42, 0,  32'h5A_03_00_03, 1'b0};  // first bad addr
        vt[8]  = '{40'hA5_57_02_A5_F0, 95, 32'h5A_00_00_00, 1'b1};  // A5 as data, long gaps
        vt[9]  = '{40'hA5_11_03_C4_00, 0,  32'h5A_01_00_01, 1'b0};  // checksum beats cmd
        vt[10] = '{40'hA5_52_0F_00_5D, 2,  32'h5A_00_5A_5A, 1'b0};  // read 0F

        rst = 1'b1; received = 1'b0; recv_error = 1'b0; rx_byte = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 12);
        repeat (3) tick();
        check("reset outputs", {12'h0, transmit, tx_byte, reg_we, reg_addr, reg_wdata, frame_ok, frame_err, busy},
              32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            do_frame($sformatf("vec%0d", i), vt[i].frame, vt[i].gap, vt[i].rsp, vt[i].we, 1'b1);
            if (vt[i].we) shadow[vt[i].frame[23:16]] = vt[i].frame[15:8];
        end

        // Garbage in HUNT is ignored silently.
        eb = err_n;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A); send_byte(8'h52);
        repeat (3) tick();
        check("hunt garbage err", 32'(err_n - eb), 32'd0);
        check("hunt garbage busy", 32'(busy), 32'd0);

        // recv_error after the ADDR byte aborts without a response.
        eb = err_n; sb = rise_n; wb = we_n;
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h03);
        recv_error = 1'b1; tick(); recv_error = 1'b0;
        repeat (60) tick();
        check("rx_error abort err", 32'(err_n - eb), 32'd1);
        check("rx_error abort busy", 32'(busy), 32'd0);
        check("rx_error abort tx", 32'(rise_n - sb), 32'd0);
        check("rx_error abort we", 32'(we_n - wb), 32'd0);

        // Byte and error in the same cycle: error wins.
        eb = err_n; sb = rise_n;
        send_byte(8'hA5); send_byte(8'h57);
        received = 1'b1; rx_byte = 8'h03; recv_error = 1'b1;
        tick();
        received = 1'b0; recv_error = 1'b0;
        repeat (60) tick();
        check("simult err", 32'(err_n - eb), 32'd1);
        check("simult busy", 32'(busy), 32'd0);
        check("simult tx", 32'(rise_n - sb), 32'd0);

        // Inter-byte timeout.
        eb = err_n; sb = rise_n;
        send_byte(8'hA5);
        c = cyc;
        send_byte(8'h52);
        k = 0;
        while (err_n == eb && k < T_OUT + 50) begin tick(); k++; end
        check("timeout err", 32'(err_n - eb), 32'd1);
        check("timeout window", 32'((err_cyc - c) >= T_OUT && (err_cyc - c) <= T_OUT + 3), 32'd1);
        repeat (60) tick();
        check("timeout busy", 32'(busy), 32'd0);
        check("timeout tx", 32'(rise_n - sb), 32'd0);

        // Bytes arriving during a response are ignored.
        rb = rx_n; sb = rise_n; eb = err_n; wb = ok_n;
        for (int i = 0; i < 5; i++) send_byte(vt[1].frame[39-8*i -: 8]);
        k = 0;
        while (rise_n == sb && k < 50) begin tick(); k++; end
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h52); send_byte(8'hA5);
        wait_resp(rb, rsp);
        repeat (5) tick();
        check("duplex rsp", rsp, 32'h5A_00_3C_3C);
        check("duplex ok", 32'(ok_n - wb), 32'd1);
        check("duplex err", 32'(err_n - eb), 32'd0);
        check("duplex busy", 32'(busy), 32'd0);
        check("duplex bytes", 32'(rx_n - rb), 32'd4);

        // Asynchronous reset during RESP_BUSY.
        for (int i = 0; i < 5; i++) send_byte(vt[1].frame[39-8*i -: 8]);
        k = 0;
        while (!transmit && k < 50) begin tick(); k++; end
        check("pre-reset transmit", 32'(transmit), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async reset transmit", 32'(transmit), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 12);
        tick();
        do_frame("post-reset", 40'hA5_57_03_C4_90, 0, 32'h5A_00_00_00, 1'b1, 1'b0);
        shadow[3] = 8'hC4;

        // Random frames against the reference rules.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] cm, ad, da, ck, st, rd;
            bit wr;
            int sel;
            sel = $urandom_range(0, 9);
            cm = (sel < 5) ? 8'h57 : (sel < 9) ? 8'h52 : 8'($urandom);
            ad = 8'($urandom_range(0, 23));
            da = 8'($urandom);
            ck = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (cm ^ ad ^ da);
            if ((cm ^ ad ^ da) != ck)              st = 8'h01;
            else if (cm != 8'h57 && cm != 8'h52)   st = 8'h02;
            else if (int'(ad) >= NREGS)            st = 8'h03;
            else                                   st = 8'h00;
            wr = (st == 8'h00) && (cm == 8'h57);
            rd = (st == 8'h00 && cm == 8'h52) ? shadow[ad] : 8'h00;
            do_frame($sformatf("rand%0d", r), {8'hA5, cm, ad, da, ck}, $urandom_range(0, 4),
                     {8'h5A, st, rd, st ^ rd}, wr, 1'b1);
            if (wr) shadow[ad] = da;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
